// File: rtl/fifo_umbral_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_umbral_pkg
// Description : Shared defaults for the thresholded FIFO: geometry, reset
//               values of the almost-full / almost-empty thresholds, the
//               push/pop operation encoding and a threshold saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_umbral_pkg;

    localparam int DEFAULT_DATA_WIDTH = 6;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

    // Threshold register values after reset, in words.
    localparam int AF_DEFAULT = 6;
    localparam int AE_DEFAULT = 1;

    // Accepted operation in a cycle: {push accepted, pop accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Clamp a requested threshold to the FIFO depth.
    function automatic int unsigned sat_threshold(input int unsigned value,
                                                  input int unsigned depth);
        return (value > depth) ? depth : value;
    endfunction

endpackage : fifo_umbral_pkg
`default_nettype wire

// File: rtl/fifo_umbral_mem_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo
// Description : Simple dual-port storage for fifo_umbral. One synchronous
//               write port, one read port with a registered output that holds
//               its value when no read is requested. The array itself is not
//               reset; only the read register is.
// Ports       : clk, i_reset_L (async, active-low)
//               i_wr_en / i_wr_addr / i_wr_data : write port
//               i_rd_en / i_rd_addr / o_rd_data : registered read port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_reset_L,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write: when both ports hit the same address in one cycle
    // (push and pop while full) the old word is returned.
    always_ff @(posedge clk or negedge i_reset_L) begin
        if (!i_reset_L) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : mem_fifo
`default_nettype wire

// File: rtl/fifo_umbral.sv
`default_nettype none
// ============================================================================
// Module      : fifo_umbral
// Description : 8-deep synchronous FIFO with programmable almost-full and
//               almost-empty thresholds and a sticky overflow/underflow flag.
// Ports       : clk, reset_L (async, active-low)
//               init, umbral_af, umbral_ae : threshold capture
//               push, data_in              : write side
//               pop, data_out, valid_out   : read side (1-cycle latency)
//               full, empty, almost_full, almost_empty, error : status
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    // Depth expressed in the counter's own width (only the MSB set).
    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_valid;
    logic                  r_error;
    logic [ADDR_WIDTH:0]   r_af;
    logic [ADDR_WIDTH:0]   r_ae;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_error_evt;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH:0]   w_af_sat;
    logic [ADDR_WIDTH:0]   w_ae_sat;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is still accepted when a pop frees the slot in
    // the same cycle; a pop from an empty FIFO is never accepted, even if a
    // push arrives alongside it.
    assign w_push_ok   = push && (!w_full || pop);
    assign w_pop_ok    = pop && !w_empty;
    assign w_error_evt = (pop && w_empty) || (push && w_full && !pop);

    always_comb begin
        w_op = fifo_op_e'({w_push_ok, w_pop_ok});
    end

    assign w_af_sat = (ADDR_WIDTH+1)'(sat_threshold(32'(umbral_af), 32'(c_DEPTH)));
    assign w_ae_sat = (ADDR_WIDTH+1)'(sat_threshold(32'(umbral_ae), 32'(c_DEPTH)));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_af     <= (ADDR_WIDTH+1)'(AF_DEFAULT);
            r_ae     <= (ADDR_WIDTH+1)'(AE_DEFAULT);
        end else begin
            case (w_op)
                OP_PUSH: r_count <= r_count + (ADDR_WIDTH+1)'(1);
                OP_POP:  r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end

            r_valid <= w_pop_ok;

            if (w_error_evt) begin
                r_error <= 1'b1;
            end

            if (init) begin
                r_af <= w_af_sat;
                r_ae <= w_ae_sat;
            end
        end
    end

    mem_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_reset_L (reset_L),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    assign valid_out    = r_valid;
    assign error        = r_error;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= r_af);
    assign almost_empty = (r_count <= r_ae);

endmodule : fifo_umbral
`default_nettype wire

// File: tb/tb_fifo_umbral.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_umbral
// Description : Self-checking bench for fifo_umbral. A behavioural queue
//               predicts contents, flags and the sticky error; popped words
//               go through a scoreboard queue and are matched against
//               data_out when valid_out is expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_umbral;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [3:0] umbral_af;
    logic [3:0] umbral_ae;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] model[$];
    logic [5:0] exp_q[$];
    int         m_af   = 6;
    int         m_ae   = 1;
    logic       m_err  = 1'b0;
    logic [5:0] m_dout = 6'h00;

    fifo_umbral dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int sat8(input int v);
        return (v > 8) ? 8 : v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int sz;
        sz = model.size();
        chk({tag, ".full"},   16'(full),         16'(sz == 8));
        chk({tag, ".empty"},  16'(empty),        16'(sz == 0));
        chk({tag, ".af"},     16'(almost_full),  16'(sz >= m_af));
        chk({tag, ".ae"},     16'(almost_empty), 16'(sz <= m_ae));
        chk({tag, ".error"},  16'(error),        16'(m_err));
    endtask

    // Called just after a falling edge: drives one cycle of stimulus, updates
    // the model, checks outputs 1 ns after the rising edge, returns at the
    // next falling edge.
    task automatic cycle(input string tag, input logic p, input logic [5:0] d, input logic q);
        bit e_pop;
        bit e_push;
        push    = p;
        data_in = d;
        pop     = q;
        e_pop   = q && (model.size() > 0);
        e_push  = p && ((model.size() < 8) || q);
        if ((q && model.size() == 0) || (p && model.size() == 8 && !q))
            m_err = 1'b1;
        if (init) begin
            m_af = sat8(int'(umbral_af));
            m_ae = sat8(int'(umbral_ae));
        end
        if (e_pop)  exp_q.push_back(model.pop_front());
        if (e_push) model.push_back(d);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 16'(valid_out), 16'(e_pop));
        if (e_pop) m_dout = exp_q.pop_front();
        chk({tag, ".data"}, 16'(data_out), 16'(m_dout));
        chk_flags(tag);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        reset_L   = 1'b0;
        init      = 1'b0;
        umbral_af = 4'd0;
        umbral_ae = 4'd0;
        push      = 1'b0;
        data_in   = 6'h00;
        pop       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.data",  16'(data_out),  16'h0);
        chk("rst.valid", 16'(valid_out), 16'h0);
        chk_flags("rst");

        // Fill 0x01..0x08; first push lands on the first edge after release
        reset_L = 1'b1;
        for (int i = 1; i <= 8; i++) cycle($sformatf("fill%0d", i), 1'b1, 6'(i), 1'b0);
        // Drain: data 0x01..0x08 one cycle after each pop
        for (int i = 1; i <= 8; i++) cycle($sformatf("drain%0d", i), 1'b0, 6'h00, 1'b1);

        // Simultaneous push/pop while full
        for (int i = 0; i < 8; i++) cycle("refill", 1'b1, 6'(8'h10 + i), 1'b0);
        cycle("full_pushpop", 1'b1, 6'h3F, 1'b1);
        for (int i = 0; i < 8; i++) cycle($sformatf("drain3f_%0d", i), 1'b0, 6'h00, 1'b1);

        // Underflow, then overflow without pop; stored data must survive
        cycle("pop_empty", 1'b0, 6'h00, 1'b1);
        for (int i = 0; i < 8; i++) cycle("fill_ovf", 1'b1, 6'(8'h20 + i), 1'b0);
        cycle("push_full", 1'b1, 6'h2A, 1'b0);
        for (int i = 0; i < 8; i++) cycle($sformatf("drain_ovf%0d", i), 1'b0, 6'h00, 1'b1);

        // Custom thresholds af=3, ae=0
        init = 1'b1; umbral_af = 4'd3; umbral_ae = 4'd0;
        cycle("init", 1'b0, 6'h00, 1'b0);
        init = 1'b0;
        for (int i = 0; i < 3; i++) cycle($sformatf("thr%0d", i), 1'b1, 6'(8'h05 + i), 1'b0);

        // Out-of-range thresholds saturate to 8
        init = 1'b1; umbral_af = 4'd15; umbral_ae = 4'd9;
        cycle("init_sat", 1'b0, 6'h00, 1'b0);
        init = 1'b0;
        for (int i = 0; i < 2; i++) cycle($sformatf("sat%0d", i), 1'b1, 6'(8'h30 + i), 1'b0);

        // Asynchronous reset between edges with 5 words stored
        #2;
        reset_L = 1'b0;
        #1;
        model.delete();
        exp_q.delete();
        m_af = 6; m_ae = 1; m_err = 1'b0; m_dout = 6'h00;
        chk("arst.data",  16'(data_out),  16'h0);
        chk("arst.valid", 16'(valid_out), 16'h0);
        chk_flags("arst");
        @(negedge clk);

        // Release; push+pop on empty at the first edge: push kept, error set
        reset_L = 1'b1;
        cycle("post_rst", 1'b1, 6'h15, 1'b1);
        for (int i = 0; i < 5; i++) cycle($sformatf("post_fill%0d", i), 1'b1, 6'(8'h01 + 3 * i), 1'b0);
        for (int i = 0; i < 6; i++) cycle($sformatf("post_drain%0d", i), 1'b0, 6'h00, 1'b1);
        cycle("idle", 1'b0, 6'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_umbral
`default_nettype wire
